// File: rtl/inst_fetch_buf_pkg.sv
// Shared constants, types and helpers for the instruction prefetch buffer.
// Optional performance counters are enabled with the FETCH_PERF_EN macro.
package inst_fetch_buf_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;
  localparam logic [31:0] PC_STEP     = 32'h0000_0004;
  localparam logic        RST_ENABLE  = 1'b1;
  localparam logic        CHIP_ENABLE = 1'b1;
  localparam logic        CHIP_DISABLE = 1'b0;

  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_RUN  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_buf_if.sv
// ROM and core-side fetch signals of the prefetch buffer, bundled with master/slave views.
// FETCH_PERF_EN adds the starvation and redirect counter outputs.
interface inst_fetch_buf_if;
  logic        rom_ce_o;
  logic [31:0] rom_addr_o;
  logic [31:0] rom_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_ready_i;
`ifdef FETCH_PERF_EN
  logic [31:0] starve_cnt_o;
  logic [31:0] redirect_cnt_o;
`endif

  modport master (
    input  rom_data_i, redirect_i, redirect_pc_i, inst_ready_i,
`ifdef FETCH_PERF_EN
    output starve_cnt_o, redirect_cnt_o,
`endif
    output rom_ce_o, rom_addr_o, inst_valid_o, inst_o, inst_pc_o
  );

  modport slave (
    output rom_data_i, redirect_i, redirect_pc_i, inst_ready_i,
`ifdef FETCH_PERF_EN
    input  starve_cnt_o, redirect_cnt_o,
`endif
    input  rom_ce_o, rom_addr_o, inst_valid_o, inst_o, inst_pc_o
  );

endinterface

// File: rtl/inst_fetch_buf_fetch_fifo.sv
// Small power-of-two FIFO holding {pc, inst} pairs; flush empties it in one cycle.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o
);

  localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_s, do_pop_s;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign do_pop_s  = pop_i & (count_q != {CNT_W{1'b0}}) & ~flush_i;
  assign do_push_s = push_i & (~full_o | do_pop_s) & ~flush_i;
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop_s)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible when count says so.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/inst_fetch_buf.sv
// Instruction prefetch buffer: sequential ROM fetch into a FIFO, valid/ready delivery, redirect flush.
// Define FETCH_PERF_EN to add the starvation and redirect counters.
module inst_fetch_buf
  import inst_fetch_buf_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_buf_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic             run_s, valid_s, pop_s, push_s, full_s;
  logic [CNT_W-1:0] count_s;
  logic [63:0]      head_raw_s;
  fetch_entry_t     head_s;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (bus.redirect_i),
    .wdata_i ({fetch_pc_q, bus.rom_data_i}),
    .head_o  (head_raw_s),
    .count_o (count_s),
    .full_o  (full_s)
  );

  assign head_s = head_raw_s;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= FS_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // Redirect wins over push and pop: it masks delivery and refetch in its own cycle.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      FS_IDLE: state_d = FS_RUN;
      FS_RUN:  state_d = FS_RUN;
      default: state_d = FS_IDLE;
    endcase
    run_s   = (state_q == FS_RUN);
    valid_s = (count_s != {CNT_W{1'b0}}) & ~bus.redirect_i;
    pop_s   = valid_s & bus.inst_ready_i;
    push_s  = run_s & ~bus.redirect_i & (~full_s | pop_s);
    if (bus.redirect_i) begin
      fetch_pc_d = align_pc(bus.redirect_pc_i);
    end else if (push_s) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  assign bus.rom_ce_o     = push_s ? CHIP_ENABLE : CHIP_DISABLE;
  assign bus.rom_addr_o   = run_s ? fetch_pc_q : ZERO_WORD;
  assign bus.inst_valid_o = valid_s;
  assign bus.inst_o       = valid_s ? head_s.inst : ZERO_WORD;
  assign bus.inst_pc_o    = valid_s ? head_s.pc : ZERO_WORD;

`ifdef FETCH_PERF_EN
  logic [31:0] starve_cnt_q, redirect_cnt_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      starve_cnt_q   <= ZERO_WORD;
      redirect_cnt_q <= ZERO_WORD;
    end else begin
      if (bus.inst_ready_i && !valid_s && (starve_cnt_q != 32'hFFFF_FFFF))
        starve_cnt_q <= starve_cnt_q + 32'd1;
      if (bus.redirect_i && (redirect_cnt_q != 32'hFFFF_FFFF))
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
    end
  end

  assign bus.starve_cnt_o   = starve_cnt_q;
  assign bus.redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf: vector table, directed corner cases and a queue-based random model.
module tb_inst_fetch_buf;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC_B = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  inst_fetch_buf_if ifa();
  inst_fetch_buf_if ifb();

  // ROM word i holds the value i.
  assign ifa.rom_data_i = {2'b00, ifa.rom_addr_o[31:2]};
  assign ifb.rom_data_i = {2'b00, ifb.rom_addr_o[31:2]};

  inst_fetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  inst_fetch_buf #(.DEPTH(DEPTH), .RESET_PC(RPC_B))         dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        m_q[$];
  bit          m_run = 1'b0;
  logic [31:0] m_pc = 32'h0;
  int unsigned m_starve = 0, m_redir = 0;
  bit          e_valid, e_ce, e_pop;
  logic [31:0] e_pc, e_inst, e_addr;
  bit          cur_rst, cur_red, cur_rdy;
  logic [31:0] cur_rpc;

  task automatic drive(input bit r, input bit red, input logic [31:0] rpc, input bit rdy);
    rst_a = r; ifa.redirect_i = red; ifa.redirect_pc_i = rpc; ifa.inst_ready_i = rdy;
    cur_rst = r; cur_red = red; cur_rpc = rpc; cur_rdy = rdy;
    e_valid = (m_q.size() != 0) && !red;
    e_pop   = e_valid && rdy;
    e_ce    = m_run && !red && ((m_q.size() < DEPTH) || e_pop);
    e_addr  = m_run ? m_pc : 32'h0;
    e_pc    = 32'h0;
    e_inst  = 32'h0;
    if (e_valid) begin
      e_pc   = m_q[0].pc;
      e_inst = m_q[0].inst;
    end
    #2;
  endtask

  task automatic model_check();
    check("valid", 32'(ifa.inst_valid_o), 32'(e_valid));
    check("pc",    ifa.inst_pc_o, e_pc);
    check("inst",  ifa.inst_o, e_inst);
    check("ce",    32'(ifa.rom_ce_o), 32'(e_ce));
    check("addr",  ifa.rom_addr_o, e_addr);
  endtask

  task automatic tick();
    @(posedge clk);
    if (cur_rst) begin
      m_run = 1'b0; m_pc = 32'h0; m_q.delete(); m_starve = 0; m_redir = 0;
    end else begin
      if (cur_rdy && !e_valid) m_starve++;
      if (cur_red) begin
        m_redir++;
        m_q.delete();
        m_pc = {cur_rpc[31:2], 2'b00};
      end else begin
        if (e_pop) void'(m_q.pop_front());
        if (e_ce) begin
          m_q.push_back('{m_pc, m_pc >> 2});
          m_pc = m_pc + 32'd4;
        end
      end
      m_run = 1'b1;
    end
    #1;
  endtask

  task automatic step(input bit r, input bit red, input logic [31:0] rpc, input bit rdy);
    drive(r, red, rpc, rdy);
    model_check();
    tick();
  endtask

  task automatic perf_check(input logic [31:0] exp_starve, input logic [31:0] exp_redir);
`ifdef FETCH_PERF_EN
    check("starve_cnt",   ifa.starve_cnt_o,   exp_starve);
    check("redirect_cnt", ifa.redirect_cnt_o, exp_redir);
`else
    if (exp_starve == 32'hFFFF_FFFF && exp_redir == 32'hFFFF_FFFF) $display("perf counters absent");
`endif
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          valid;
    logic [31:0] pc;
    bit          ce;
    logic [31:0] addr;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int          ces;
    int          got;
    logic [31:0] got_pc[3];
    logic [31:0] got_inst[3];

    rst_b = 1'b1; ifb.redirect_i = 1'b0; ifb.redirect_pc_i = 32'h0; ifb.inst_ready_i = 1'b1;

    tbl[0]  = '{1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b0, 32'h00};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h04};
    tbl[4]  = '{1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h08};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0C};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h10};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b1, 32'h14};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h08, 1'b0, 32'h18};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h18};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h1C};

    drive(1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].rst, 1'b0, 32'h0, tbl[i].rdy);
      model_check();
      check("tbl_valid", 32'(ifa.inst_valid_o), 32'(tbl[i].valid));
      check("tbl_pc",    ifa.inst_pc_o, tbl[i].pc);
      check("tbl_inst",  ifa.inst_o, tbl[i].valid ? (tbl[i].pc >> 2) : 32'h0);
      check("tbl_ce",    32'(ifa.rom_ce_o), 32'(tbl[i].ce));
      check("tbl_addr",  ifa.rom_addr_o, tbl[i].addr);
      tick();
    end

    // Stalled core: exactly DEPTH pushes, then in-order drain with no gap.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    ces = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0);
      model_check();
      if (ifa.rom_ce_o) ces++;
      tick();
    end
    check("s2_pushes", 32'(ces), 32'd4);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b1);
      model_check();
      check("s2_drain_valid", 32'(ifa.inst_valid_o), 32'd1);
      check("s2_drain_pc", ifa.inst_pc_o, 32'(4 * i));
      tick();
    end

    // Redirect with three queued entries.
    step(1'b1, 1'b0, 32'h0, 1'b1);
    perf_check(32'd0, 32'd0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 32'h0000_0103, 1'b1);
    model_check();
    check("s3_valid_redir", 32'(ifa.inst_valid_o), 32'd0);
    tick();
    perf_check(32'(m_starve), 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("s3_valid_next", 32'(ifa.inst_valid_o), 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("s3_first_valid", 32'(ifa.inst_valid_o), 32'd1);
    check("s3_first_pc", ifa.inst_pc_o, 32'h0000_0100);
    check("s3_first_inst", ifa.inst_o, 32'h0000_0040);
    tick();

    // Back-to-back redirects: the later target wins.
    step(1'b0, 1'b1, 32'h0000_0040, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0080, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("s4_gap_valid", 32'(ifa.inst_valid_o), 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("s4_first_pc", ifa.inst_pc_o, 32'h0000_0080);
    tick();
    perf_check(32'(m_starve), 32'(m_redir));

    // One-cycle reset with a full FIFO.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_0200, 1'b0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("s6_valid", 32'(ifa.inst_valid_o), 32'd0);
    check("s6_inst",  ifa.inst_o, 32'h0);
    check("s6_pc",    ifa.inst_pc_o, 32'h0);
    check("s6_ce",    32'(ifa.rom_ce_o), 32'd0);
    check("s6_addr",  ifa.rom_addr_o, 32'h0);
    perf_check(32'd0, 32'd0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("s6_restart_ce", 32'(ifa.rom_ce_o), 32'd1);
    check("s6_restart_addr", ifa.rom_addr_o, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    check("s6_restart_pc", ifa.inst_pc_o, 32'h0);
    check("s6_restart_valid", 32'(ifa.inst_valid_o), 32'd1);
    tick();

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(63) == 0), ($urandom_range(15) == 0), $urandom, ($urandom_range(3) != 0));
      perf_check(32'(m_starve), 32'(m_redir));
    end

    // PC wrap with a high reset address.
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst_b = 1'b0;
    got = 0;
    for (int c = 0; c < 12 && got < 3; c++) begin
      #2;
      if (ifb.inst_valid_o) begin
        got_pc[got]   = ifb.inst_pc_o;
        got_inst[got] = ifb.inst_o;
        got++;
      end
      @(posedge clk); #1;
    end
    check("s5_count", 32'(got), 32'd3);
    if (got == 3) begin
      check("s5_pc0", got_pc[0], 32'hFFFF_FFF8);
      check("s5_pc1", got_pc[1], 32'hFFFF_FFFC);
      check("s5_pc2", got_pc[2], 32'h0000_0000);
      check("s5_inst0", got_inst[0], 32'h3FFF_FFFE);
      check("s5_inst2", got_inst[2], 32'h0000_0000);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
